branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Fetch-stage branch predictor for the 5-stage RV32I pipeline: direct-mapped BTB plus 2-bit saturating PHT.
//  Looks up pc_f combinationally, supplies predicted next PC to the F-stage PC mux.
//  Trained non-speculatively by the EX stage when a branch/jump resolves.
//  EX keeps mispredict detection/flush; this block only predicts and learns.
// PARAMETERS
//  XLEN     32  data/address width
//  ENTRIES  64  BTB/PHT entry count; power of 2, >=4
//  TAG_W    8   BTB tag bits taken above the index field
//  GHR_W    6   global history length; used only with BP_GSHARE_EN; GHR_W <= IDX_W
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  pc_f          in   XLEN   fetch PC to predict
//  pred_taken    out  1      predict redirect for pc_f
//  pred_target   out  XLEN   predicted target; valid when pred_taken
//  upd_valid     in   1      EX resolved a control-transfer this cycle (asserted once per instr; never when flushed)
//  upd_pc        in   XLEN   PC of resolved instruction
//  upd_is_jump   in   1      1 = JAL/JALR (unconditional), 0 = conditional branch
//  upd_taken     in   1      actual outcome (always 1 for jumps)
//  upd_target    in   XLEN   actual target (pc_target_e)
// BEHAVIOUR
//  IDX_W = $clog2(ENTRIES); idx(pc) = pc[IDX_W+1:2]; tag(pc) = pc[IDX_W+2 +: TAG_W]; pc[1:0] ignored.
//  BTB entry = {valid, tag, target, is_jump}; PHT entry = 2-bit ctr: 00 SNT, 01 WNT, 10 WT, 11 ST.
//  Lookup (comb, 0-cycle): hit = valid[idx] & tag match. pred_taken = hit & (is_jump | pht[pidx][1]).
//  pred_target = btb target if hit, else 0. pidx = idx(pc_f) (see CONFIGURATION).
//  Update on posedge when upd_valid:
//   - hit & taken: overwrite target/is_jump; ctr = sat-inc (11 stays 11).
//   - hit & not taken: ctr = sat-dec (00 stays 00); target unchanged.
//   - miss & taken: allocate (valid=1, tag, target, is_jump); ctr = 10 (WT), replaces any prior entry.
//   - miss & not taken: no change.
//  Same-cycle lookup and update to the same entry: lookup sees pre-update state; no bypass.
//  Jumps also update the ctr; prediction ignores it via is_jump.
//  Reset: all valid = 0, all ctr = 01 (WNT), GHR = 0.
//   Outputs then pred_taken = 0, pred_target = 0. rst overrides a coincident upd_valid.
//   Reset mid-training leaves no partial entry.
//  JALR targets are predicted as last-seen target (no RAS); wrong targets are caught by EX as mispredicts.
//  Table aliasing between different PCs is permitted; only tag mismatch suppresses prediction.
// CONFIGURATION
//  BP_GSHARE_EN defined:
//   - pidx = idx XOR {{(IDX_W-GHR_W){1'b0}}, ghr}, for both lookup (pc_f) and update (upd_pc).
//   - GHR shifts left, inserting upd_taken, on upd_valid & !upd_is_jump, at the same edge as the PHT write.
//   - The update uses the pre-shift GHR.
//  BP_GSHARE_EN undefined: pidx = idx; no GHR flops exist; GHR_W unused.
// STRUCTURE
//  Package bp_pkg: ctr_t enum (SNT/WNT/WT/ST), CTR_RESET = WNT, CTR_ALLOC = WT,
//   btb_entry_t struct parametrised via localparams, sat_inc/sat_dec functions.
//  Sub-module bp_pht: ENTRIES x 2-bit counter array.
//   Ports: clk, rst, rd_idx, rd_ctr, wr_en, wr_idx, wr_taken, wr_alloc.
//  BTB arrays and GHR stay in branch_predictor. Storage is flops (reset required), not SRAM.
// TESTING
//  1. Reset, pc_f=0x40 -> pred_taken=0, pred_target=0.
//  2. upd {pc=0x40, branch, taken, tgt=0x100}; next cycle pc_f=0x40 -> pred_taken=1, tgt 0x100 (ctr=WT).
//  3. From 2, two not-taken updates for 0x40 -> ctr WT->WNT->SNT, pred_taken=0.
//     Four taken updates -> ST; one not-taken -> WT, still predicts taken.
//  4. Alias, ENTRIES=64: allocate 0x40, then taken upd 0x1040 (same idx, different tag).
//     pc_f=0x40 -> pred_taken=0; pc_f=0x1040 -> hit.
//  5. JAL at 0x80 -> 0x200 trained, then not-taken-style ctr decrements -> pred_taken stays 1.
//     Same-cycle upd and lookup of 0x80 with new tgt 0x300 -> old 0x200 that cycle, 0x300 next.
//  6. rst asserted with upd_valid=1 -> next cycle all lookups miss.
//     BP_GSHARE_EN: alternating T/N branch at 0xC0 predicted correctly after warm-up (>=8 updates).

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit PHT counter encoding,
// BTB entry layout and the saturating counter helpers.
package bp_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]  target;
        logic                 is_jump;
    } btb_entry_t;

    function automatic ctr_t sat_inc(input ctr_t c);
        ctr_t r;
        unique case (c)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        ctr_t r;
        unique case (c)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: ENTRIES x 2-bit saturating counters, one async read port
// and one write port that either allocates (forces WT) or trains up/down.
module bp_pht
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken,
    input  logic             wr_alloc
);

    ctr_t ctr_q [ENTRIES];
    ctr_t ctr_d;

    always_comb begin
        ctr_d = ctr_q[wr_idx];
        if (wr_alloc) begin
            ctr_d = CTR_ALLOC;
        end else if (wr_taken) begin
            ctr_d = sat_inc(ctr_q[wr_idx]);
        end else begin
            ctr_d = sat_dec(ctr_q[wr_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_d;
        end
    end

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB plus 2-bit PHT, 0-cycle lookup of pc_f,
// trained by EX on resolution. Define BP_GSHARE_EN to hash the PHT index with global history.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int GHR_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;

    btb_entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx, f_pidx, u_pidx;
    logic [TAG_W-1:0] f_tag, u_tag;
    btb_entry_t       f_ent;
    logic             f_hit, u_hit;
    ctr_t             f_ctr;

    assign f_idx = pc_f[IDX_W+1:2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign f_tag = pc_f[TAG_LSB +: TAG_W];
    assign u_tag = upd_pc[TAG_LSB +: TAG_W];

    // Bits outside index/tag take no part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_f[1:0], pc_f[XLEN-1:TAG_LSB+TAG_W],
                              upd_pc[1:0], upd_pc[XLEN-1:TAG_LSB+TAG_W]};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    assign f_pidx = f_idx ^ IDX_W'(ghr_q);
    assign u_pidx = u_idx ^ IDX_W'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid && !upd_is_jump) begin
            ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    localparam int unused_ghr_w = GHR_W;

    assign f_pidx = f_idx;
    assign u_pidx = u_idx;
`endif

    assign f_ent = btb_q[f_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
    assign u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);

    // Taken outcomes always (re)write the entry: a hit refreshes the target, a miss evicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, is_jump: upd_is_jump};
        end
    end

    bp_pht #(
        .ENTRIES (ENTRIES)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_pidx),
        .rd_ctr   (f_ctr),
        .wr_en    (upd_valid && (u_hit || upd_taken)),
        .wr_idx   (u_pidx),
        .wr_taken (upd_taken),
        .wr_alloc (!u_hit)
    );

    assign pred_taken  = f_hit && (f_ent.is_jump || f_ctr[1]);
    assign pred_target = f_hit ? f_ent.target : '0;

endmodule
